// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into single APB transfers and returns one response each.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_cmd_master #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic             PCLK,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic             busy,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [WIDTH-1:0] PADDR,
    output logic [WIDTH-1:0] PWDATA,
    input  logic             PREADY,
    input  logic             PSLVERR,
    input  logic [WIDTH-1:0] PRDATA
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e           state_q, state_d;
    logic             psel_q, psel_d;
    logic             penable_q, penable_d;
    logic             pwrite_q, pwrite_d;
    logic [WIDTH-1:0] paddr_q, paddr_d;
    logic [WIDTH-1:0] pwdata_q, pwdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;
    logic             expire;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts ACCESS cycles without PREADY; expire marks the last permitted one.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (state_q == ACCESS && !PREADY) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign expire     = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE) && !reset;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // PREADY on the expiring cycle takes priority over the abort.
                if (PREADY) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = pwrite_q ? '0 : PRDATA;
                    err_d       = PSLVERR;
                    tmo_d       = 1'b0;
                end else if (expire) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    tmo_d       = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed APB transfers, scoreboard of expected responses, monitor on rsp handshake.
module tb_apb_cmd_master;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned TMO   = 16;
`ifdef APB_TIMEOUT_EN
    localparam int STALL = 5;
`else
    localparam int STALL = 1000;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] rdata;
        logic             err;
        logic             tmo;
    } rsp_t;

    logic             PCLK = 1'b0;
    logic             reset;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [WIDTH-1:0] cmd_addr, cmd_wdata;
    logic             rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [WIDTH-1:0] rsp_rdata;
    logic             PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [WIDTH-1:0] PADDR, PWDATA, PRDATA;

    int    vectors     = 0;
    int    miscompares = 0;
    rsp_t  sb[$];
    rsp_t  exp_e;
    int    n_en;
    int    acc;
    bit    done;
    bit    hs;
    logic [11:0] psel_hist, rv_hist;
    logic        bb_wr[3];
    logic [7:0]  bb_addr[3];
    logic [7:0]  bb_wdata[3];

    apb_cmd_master #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each rsp handshake (sampled mid-cycle).
    always @(negedge PCLK) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("stale_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
            end
        end
    end

    task automatic do_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input int waits, input logic [7:0] rdata, input logic err,
                           input int rsp_delay, input logic hold_cmd);
        rsp_t e;
        e.rdata = wr ? 8'h00 : rdata;
        e.err   = err;
        e.tmo   = 1'b0;
        sb.push_back(e);
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        PREADY = 1'b0; rsp_ready = (rsp_delay == 0);
        @(negedge PCLK);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
        @(negedge PCLK);
        chk("setup_psel", 32'(PSEL), 32'd1);
        chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("setup_paddr", 32'(PADDR), 32'(addr));
        chk("setup_pwrite", 32'(PWRITE), 32'(wr));
        for (int i = 0; i <= waits; i++) begin
            @(posedge PCLK); #1;
            if (i == waits) begin
                PREADY = 1'b1; PRDATA = rdata; PSLVERR = err;
            end
            @(negedge PCLK);
            chk("access_psel", 32'(PSEL), 32'd1);
            chk("access_penable", 32'(PENABLE), 32'd1);
            chk("access_paddr", 32'(PADDR), 32'(addr));
            if (wr) chk("access_pwdata", 32'(PWDATA), 32'(wdata));
        end
        @(posedge PCLK); #1;
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 8'hEE;
        cmd_valid = hold_cmd;
        for (int j = 0; j < rsp_delay; j++) begin
            @(negedge PCLK);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("stall_psel", 32'(PSEL), 32'd0);
            chk("stall_rsp_err", 32'(rsp_err), 32'(err));
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_psel", 32'(PSEL), 32'd0);
        chk("resp_penable", 32'(PENABLE), 32'd0);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        repeat (3) @(posedge PCLK);
        #1 reset = 1'b0;
        @(negedge PCLK);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        do_xfer(1'b1, 8'h04, 8'hA5, 0, 8'h99, 1'b0, 0, 1'b0);
        do_xfer(1'b0, 8'h08, 8'h00, 3, 8'h3C, 1'b0, 0, 1'b0);
        do_xfer(1'b1, 8'h0C, 8'h5E, 0, 8'h00, 1'b1, 5, 1'b1);
        do_xfer(1'b0, 8'h60, 8'h00, 15, 8'h77, 1'b0, 0, 1'b0);

`ifdef APB_TIMEOUT_EN
        exp_e.rdata = 8'h00; exp_e.err = 1'b1; exp_e.tmo = 1'b1;
        sb.push_back(exp_e);
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; PREADY = 1'b0; rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        n_en = 0; done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge PCLK);
            if (rsp_valid) done = 1'b1;
            else if (PENABLE) n_en++;
        end
        chk("tmo_reached", 32'(done), 32'd1);
        chk("tmo_access_cycles", 32'(n_en), 32'(TMO));
        chk("tmo_psel_dropped", 32'(PSEL), 32'd0);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("tmo_idle", 32'(busy), 32'd0);
`endif

        // Stalled ACCESS, then asynchronous reset mid-cycle.
        exp_e.rdata = 8'h00; exp_e.err = 1'b0; exp_e.tmo = 1'b0;
        sb.push_back(exp_e);
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h50; PREADY = 1'b0; rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        repeat (STALL) @(posedge PCLK);
        #3;
        chk("stall_access_penable", 32'(PENABLE), 32'd1);
        chk("stall_access_busy", 32'(busy), 32'd1);
        chk("stall_access_no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("async_rst_psel", 32'(PSEL), 32'd0);
        chk("async_rst_penable", 32'(PENABLE), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge PCLK); #1;
        reset = 1'b0; PREADY = 1'b1;
        @(negedge PCLK);
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (4) begin
            @(negedge PCLK);
            chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end

        // Three commands back-to-back with PREADY held high.
        bb_wr[0] = 1'b1; bb_addr[0] = 8'h10; bb_wdata[0] = 8'h11;
        bb_wr[1] = 1'b0; bb_addr[1] = 8'h20; bb_wdata[1] = 8'h22;
        bb_wr[2] = 1'b1; bb_addr[2] = 8'h30; bb_wdata[2] = 8'h33;
        exp_e.rdata = 8'h00; exp_e.err = 1'b0; exp_e.tmo = 1'b0; sb.push_back(exp_e);
        exp_e.rdata = 8'h5A; sb.push_back(exp_e);
        exp_e.rdata = 8'h00; sb.push_back(exp_e);
        @(posedge PCLK); #1;
        PREADY = 1'b1; PRDATA = 8'h5A; PSLVERR = 1'b0; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = bb_wr[0]; cmd_addr = bb_addr[0]; cmd_wdata = bb_wdata[0];
        acc = 0; psel_hist = '0; rv_hist = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge PCLK);
            psel_hist[c] = PSEL;
            rv_hist[c]   = rsp_valid;
            hs = cmd_valid && cmd_ready;
            if (c == 5) begin
                chk("b2b_paddr", 32'(PADDR), 32'h20);
                chk("b2b_pwrite", 32'(PWRITE), 32'd0);
            end
            @(posedge PCLK); #1;
            if (hs) begin
                acc++;
                if (acc < 3) begin
                    cmd_write = bb_wr[acc]; cmd_addr = bb_addr[acc]; cmd_wdata = bb_wdata[acc];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        chk("b2b_accepts", 32'(acc), 32'd3);
        chk("b2b_psel_pattern", 32'(psel_hist), 32'h666);
        chk("b2b_rsp_pattern", 32'(rv_hist), 32'h888);
        @(negedge PCLK);
        chk("b2b_sb_drained", 32'(sb.size()), 32'd0);
        PREADY = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
